// File: rtl/sync_delay_search.sv
// rtl/sync_delay_search.sv - exhaustive sample-phase x symbol-delay alignment search
// Purpose: sweeps every (sam_delay, sym_delay) candidate, counts ref/rx symbol
//          mismatches over a measurement window, and locks the candidate with
//          the fewest errors (earliest wins ties) until the next start.
// Optional: define SYNC_SEARCH_EARLY_EXIT_EN to lock the first zero-error
//           candidate immediately instead of finishing the sweep.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   sam_clk_en      - sample-rate enable (not used by this block)
//   sym_clk_en      - symbol-rate enable; all counting qualified by it
//   start           - begin a search (ignored while busy)
//   ref_data        - delayed reference symbol
//   rx_data         - receiver slicer decision
//   sam_delay       - sample delay line setting
//   sym_delay       - symbol/data delay line setting
//   busy            - search running
//   locked          - completed result being driven
//   done            - one-clk pulse on search completion
//   best_err        - error count of the locked candidate
module sync_delay_search #(
    parameter int SAM_PHASES    = 4,
    parameter int MAX_SYM_DELAY = 63,
    parameter int SETTLE_SYMS   = 64,
    parameter int MEAS_SYMS     = 256,
    parameter int ACC_W         = 16,
    parameter int DEF_SAM       = 2,
    parameter int DEF_SYM       = 38
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sam_clk_en,
    input  logic             sym_clk_en,
    input  logic             start,
    input  logic [1:0]       ref_data,
    input  logic [1:0]       rx_data,
    output logic [1:0]       sam_delay,
    output logic [7:0]       sym_delay,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic [ACC_W-1:0] best_err
);

    localparam int SET_W  = $clog2(SETTLE_SYMS + 1);
    localparam int MEAS_W = $clog2(MEAS_SYMS + 1);

    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_SYMS - 1);
    localparam logic [MEAS_W-1:0] MEAS_LAST   = MEAS_W'(MEAS_SYMS - 1);
    localparam logic [1:0]        LAST_SAM    = 2'(SAM_PHASES - 1);
    localparam logic [7:0]        LAST_SYM    = 8'(MAX_SYM_DELAY);
    localparam logic [1:0]        RST_SAM     = 2'(DEF_SAM);
    localparam logic [7:0]        RST_SYM     = 8'(DEF_SYM);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        COMPARE,
        NEXT,
        LOCK
    } state_t;

    state_t            state;
    logic [SET_W-1:0]  settle_cnt;
    logic [MEAS_W-1:0] meas_cnt;
    logic [ACC_W-1:0]  err_acc;
    logic [1:0]        best_sam;
    logic [7:0]        best_sym;

    logic unused_sam_clk_en;
    assign unused_sam_clk_en = sam_clk_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sam_delay  <= RST_SAM;
            sym_delay  <= RST_SYM;
            busy       <= 1'b0;
            locked     <= 1'b0;
            done       <= 1'b0;
            best_err   <= '1;
            settle_cnt <= '0;
            meas_cnt   <= '0;
            err_acc    <= '0;
            best_sam   <= '0;
            best_sym   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, LOCK: begin
                    if (start) begin
                        state      <= SETTLE;
                        sam_delay  <= '0;
                        sym_delay  <= '0;
                        busy       <= 1'b1;
                        locked     <= 1'b0;
                        best_err   <= '1;
                        settle_cnt <= '0;
                        meas_cnt   <= '0;
                        err_acc    <= '0;
                        // Default winner if no candidate beats the all-ones
                        // initial best (e.g. saturated accumulator).
                        best_sam   <= '0;
                        best_sym   <= '0;
                    end
                end

                SETTLE: begin
                    if (sym_clk_en) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            meas_cnt   <= '0;
                            err_acc    <= '0;
                            state      <= MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end

                MEASURE: begin
                    if (sym_clk_en) begin
                        if ((ref_data != rx_data) && (err_acc != '1)) begin
                            err_acc <= err_acc + 1'b1;
                        end
                        if (meas_cnt == MEAS_LAST) begin
                            state <= COMPARE;
                        end else begin
                            meas_cnt <= meas_cnt + 1'b1;
                        end
                    end
                end

                COMPARE: begin
                    // Strict compare: ties keep the earlier candidate.
                    if (err_acc < best_err) begin
                        best_err <= err_acc;
                        best_sam <= sam_delay;
                        best_sym <= sym_delay;
                    end
`ifdef SYNC_SEARCH_EARLY_EXIT_EN
                    if (err_acc == '0) begin
                        // Current candidate is already driven; just lock it.
                        state  <= LOCK;
                        busy   <= 1'b0;
                        locked <= 1'b1;
                        done   <= 1'b1;
                    end else begin
                        state <= NEXT;
                    end
`else
                    state <= NEXT;
`endif
                end

                NEXT: begin
                    if ((sam_delay == LAST_SAM) && (sym_delay == LAST_SYM)) begin
                        state     <= LOCK;
                        sam_delay <= best_sam;
                        sym_delay <= best_sym;
                        busy      <= 1'b0;
                        locked    <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        if (sym_delay < LAST_SYM) begin
                            sym_delay <= sym_delay + 1'b1;
                        end else begin
                            sym_delay <= '0;
                            sam_delay <= sam_delay + 1'b1;
                        end
                        settle_cnt <= '0;
                        meas_cnt   <= '0;
                        err_acc    <= '0;
                        state      <= SETTLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
